// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and the
// counter-width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_sub_div.sv
// Parameterised subtractor shared by the divider datapath: diff = a - b,
// where the MSB of an (N+1)-bit subtraction acts as the borrow.
module sub_div #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o
);

    assign diff_o = a_i - b_i;

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock with a
// start/done handshake; results are registered and held until the next operation.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  q_work_q, q_work_d;
    logic [N-1:0]  r_work_q, r_work_d;
    logic [N-1:0]  d_reg_q, d_reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    trial_s;
    logic [N:0]    diff_s;
    logic          borrow_s;
    logic [N-1:0]  r_step_s;
    logic [N-1:0]  q_step_s;

    // The N+1-bit trial keeps the shifted-out remainder bit so divisors above 2^(N-1) cannot overflow.
    assign trial_s = {r_work_q, q_work_q[N-1]};

    sub_div #(
        .W(N + 1)
    ) u_sub (
        .a_i   (trial_s),
        .b_i   ({1'b0, d_reg_q}),
        .diff_o(diff_s)
    );

    assign borrow_s = diff_s[N];
    assign r_step_s = borrow_s ? trial_s[N-1:0] : diff_s[N-1:0];
    assign q_step_s = {q_work_q[N-2:0], ~borrow_s};

    // Next-state, datapath and output-register updates.
    always_comb begin
        state_d     = state_q;
        q_work_d    = q_work_q;
        r_work_d    = r_work_q;
        d_reg_d     = d_reg_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_CALC: begin
                q_work_d = q_step_s;
                r_work_d = r_step_s;
                if (cnt_q == {CW{1'b0}}) begin
                    quotient_d  = q_step_s;
                    remainder_d = r_step_s;
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Covers IDLE and the unused encoding, which behaves as IDLE.
                if (start) begin
                    if (divisor != {N{1'b0}}) begin
                        q_work_d = dividend;
                        r_work_d = {N{1'b0}};
                        d_reg_d  = divisor;
                        cnt_d    = CNT_LAST;
                        state_d  = ST_CALC;
                    end else begin
                        quotient_d  = {N{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_work_q    <= {N{1'b0}};
            r_work_q    <= {N{1'b0}};
            d_reg_q     <= {N{1'b0}};
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {N{1'b0}};
            remainder_q <= {N{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_work_q    <= q_work_d;
            r_work_q    <= r_work_d;
            d_reg_q     <= d_reg_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
